// File: rtl/slice_pkg.sv
// Shared constants and FSM state encoding for the slice assembler, encoder and controller.
package slice_pkg;

    localparam int SLICE_W    = 25;
    localparam int NUM_SLICES = 64;
    localparam int IDX_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sipo_shift25.sv
// Serial-in/parallel-out register, MSB-first, with bit counter and full flag.
module sipo_shift25
    import slice_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic         bit_i,
    output logic [W-1:0] data_next_o,
    output logic         last_o,
    output logic         full_o
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [W-1:0]  sreg_q;
    logic [CW-1:0] bcnt_q;
    logic          full_q;

    assign data_next_o = {sreg_q[W-2:0], bit_i};
    assign last_o      = (bcnt_q == LAST_CNT);
    assign full_o      = full_q;

    // The counter parks on its last value once full; a clear restarts the slice.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            sreg_q <= '0;
            bcnt_q <= '0;
            full_q <= 1'b0;
        end else if (shift_i) begin
            sreg_q <= data_next_o;
            if (last_o) begin
                full_q <= 1'b1;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/slice_assembler.sv
// Assembles serial bits into slices, hands them downstream with valid/ready, and counts slices per frame.
// Optional SLICE_PARITY_EN adds a registered XOR-reduction of slice_out on port slice_parity.
module slice_assembler
    import slice_pkg::*;
#(
    parameter int SLICE_W    = slice_pkg::SLICE_W,
    parameter int NUM_SLICES = slice_pkg::NUM_SLICES,
    parameter int IDX_W      = slice_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [SLICE_W-1:0] slice_out,
    output logic               slice_valid,
    input  logic               slice_ready,
    output logic [IDX_W-1:0]   slice_idx,
    output logic               busy,
`ifdef SLICE_PARITY_EN
    output logic               slice_parity,
`endif
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     slice_idx_q, slice_idx_d;
    logic [SLICE_W-1:0]   slice_out_q, slice_out_d;
    logic [SLICE_W-1:0]   data_next;
    logic                 last_bit, full;
    logic                 frame_go, xfer, handshake, sipo_clr;

    assign frame_go  = (state_q == IDLE) && start;
    assign xfer      = bit_valid && bit_ready;
    assign handshake = (state_q == HOLD) && slice_ready && full;
    assign sipo_clr  = frame_go || handshake;

    sipo_shift25 #(
        .W (SLICE_W)
    ) u_sipo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (sipo_clr),
        .shift_i     (xfer),
        .bit_i       (bit_in),
        .data_next_o (data_next),
        .last_o      (last_bit),
        .full_o      (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (xfer && last_bit) state_d = HOLD;
            HOLD:    if (handshake) state_d = (slice_idx_q == LAST_IDX) ? DONE : SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_ready   = (state_q == SHIFT);
        slice_valid = (state_q == HOLD);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
    end

    // slice_idx stays at the last index after DONE until the next start.
    always_comb begin
        slice_idx_d = slice_idx_q;
        if (frame_go) begin
            slice_idx_d = '0;
        end else if (handshake && (slice_idx_q != LAST_IDX)) begin
            slice_idx_d = slice_idx_q + 1'b1;
        end
    end

    // Capture the completed slice on the edge that accepts its final bit.
    always_comb begin
        slice_out_d = slice_out_q;
        if (xfer && last_bit) begin
            slice_out_d = data_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slice_idx_q <= '0;
            slice_out_q <= '0;
        end else begin
            slice_idx_q <= slice_idx_d;
            slice_out_q <= slice_out_d;
        end
    end

    assign slice_idx = slice_idx_q;
    assign slice_out = slice_out_q;

`ifdef SLICE_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^slice_out_d;
        end
    end

    assign slice_parity = parity_q;
`endif

endmodule

// File: tb/tb_slice_assembler.sv
// Directed self-checking bench for slice_assembler with a two-slice frame.
// Parity checks are compiled in when SLICE_PARITY_EN is defined.
module tb_slice_assembler;

    localparam int SW  = 25;
    localparam int IW  = 6;
    localparam int NS  = 2;

    localparam logic [SW-1:0] VEC_A = 25'b1111001001001110100010111;
    localparam logic [SW-1:0] VEC_B = 25'b1001111101000101010111100;
    localparam logic [SW-1:0] VEC_C = 25'b1010100000000001010101111;
    localparam logic [SW-1:0] VEC_D = 25'b0110101010000001100000001;
    localparam logic [SW-1:0] VEC_E = 25'b1101101000001110011011001;
    localparam logic [SW-1:0] VEC_X = 25'h1555555;
    localparam logic [SW-1:0] VEC_F = 25'h0000001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          slice_ready = 1'b0;
    logic          bit_ready;
    logic [SW-1:0] slice_out;
    logic          slice_valid;
    logic [IW-1:0] slice_idx;
    logic          busy;
    logic          done;
`ifdef SLICE_PARITY_EN
    logic          slice_parity;
`endif

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    slice_assembler #(
        .SLICE_W    (SW),
        .NUM_SLICES (NS),
        .IDX_W      (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .slice_out    (slice_out),
        .slice_valid  (slice_valid),
        .slice_ready  (slice_ready),
        .slice_idx    (slice_idx),
        .busy         (busy),
`ifdef SLICE_PARITY_EN
        .slice_parity (slice_parity),
`endif
        .done         (done)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bit_ready"},   32'(bit_ready),   32'd0);
        check({tag, "_slice_valid"}, 32'(slice_valid), 32'd0);
        check({tag, "_slice_out"},   32'(slice_out),   32'd0);
        check({tag, "_slice_idx"},   32'(slice_idx),   32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_bit_ready", 32'(bit_ready), 32'd1);
    endtask

    // Feeds nbits MSB-first; before bit index gap_at inserts gap_len idle beats,
    // optionally pulsing start and slice_ready on the first idle beat.
    task automatic send_bits(input logic [SW-1:0] v, input int nbits, input int gap_at,
                             input int gap_len, input bit spur, input int exp_idx);
        for (int i = SW - 1; i >= SW - nbits; i--) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bit_valid   = 1'b0;
                    start       = spur && (g == 0);
                    slice_ready = spur && (g == 0);
                    tick();
                    start       = 1'b0;
                    slice_ready = 1'b0;
                    check("gap_bit_ready", 32'(bit_ready), 32'd1);
                    check("gap_slice_idx", 32'(slice_idx), 32'(exp_idx));
                end
            end
            if (i == 0) check("pre_last_slice_valid", 32'(slice_valid), 32'd0);
            bit_in    = v[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic expect_slice(input string tag, input logic [SW-1:0] v, input int exp_idx);
        check({tag, "_slice_valid"}, 32'(slice_valid), 32'd1);
        check({tag, "_slice_out"},   32'(slice_out),   32'(v));
        check({tag, "_slice_idx"},   32'(slice_idx),   32'(exp_idx));
        check({tag, "_bit_ready"},   32'(bit_ready),   32'd0);
        $display("slice %s idx=%0d data=0x%07h", tag, slice_idx, slice_out);
    endtask

    // Holds slice_ready low for wait_cycles (offering a stray bit), then completes the handshake.
    task automatic handshake(input string tag, input logic [SW-1:0] v, input int wait_cycles);
        for (int w = 0; w < wait_cycles; w++) begin
            bit_valid = 1'b1;
            bit_in    = ~bit_in;
            tick();
            check({tag, "_hold_out"},   32'(slice_out),   32'(v));
            check({tag, "_hold_ready"}, 32'(bit_ready),   32'd0);
            check({tag, "_hold_valid"}, 32'(slice_valid), 32'd1);
        end
        bit_valid   = 1'b0;
        slice_ready = 1'b1;
        tick();
        slice_ready = 1'b0;
        check({tag, "_post_hs_valid"}, 32'(slice_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        // Frame 1: basic slice, then a gapped slice under backpressure.
        pulse_start();
        check("f1_idx0", 32'(slice_idx), 32'd0);
        send_bits(VEC_A, SW, -1, 0, 1'b0, 0);
        expect_slice("basic", VEC_A, 0);
`ifdef SLICE_PARITY_EN
        check("parity_A", 32'(slice_parity), 32'd0);
`endif
        handshake("basic", VEC_A, 0);
        check("f1_idx1", 32'(slice_idx), 32'd1);
        check("f1_mid_bit_ready", 32'(bit_ready), 32'd1);
        d0 = done_cnt;
        send_bits(VEC_B, SW, 12, 3, 1'b0, 1);
        expect_slice("gapped", VEC_B, 1);
        handshake("gapped", VEC_B, 5);
        check("f1_done", 32'(done), 32'd1);
        check("f1_done_busy", 32'(busy), 32'd1);
        tick();
        check("f1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f1_idle_busy", 32'(busy), 32'd0);
        check("f1_idle_done", 32'(done), 32'd0);

        // Frame 2: frame end with two continuous slices.
        pulse_start();
        check("f2_idx0", 32'(slice_idx), 32'd0);
        d0 = done_cnt;
        send_bits(VEC_C, SW, -1, 0, 1'b0, 0);
        expect_slice("frame_c", VEC_C, 0);
        handshake("frame_c", VEC_C, 0);
        check("f2_no_early_done", 32'(done), 32'd0);
        send_bits(VEC_D, SW, -1, 0, 1'b0, 1);
        expect_slice("frame_d", VEC_D, 1);
        handshake("frame_d", VEC_D, 0);
        check("f2_done", 32'(done), 32'd1);
        tick();
        tick();
        tick();
        check("f2_done_once", 32'(done_cnt - d0), 32'd1);
        check("f2_idle_busy", 32'(busy), 32'd0);
        check("f2_idx_hold", 32'(slice_idx), 32'd1);
        check("f2_out_kept", 32'(slice_out), 32'(VEC_D));

        // Frame 3: reset after 10 accepted bits discards the partial slice.
        pulse_start();
        send_bits(VEC_X, 10, -1, 0, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        pulse_start();
        send_bits(VEC_E, SW, -1, 0, 1'b0, 0);
        expect_slice("after_rst", VEC_E, 0);
        handshake("after_rst", VEC_E, 0);

        // Spurious start and slice_ready after 10 bits of the second slice.
        send_bits(VEC_F, SW, 14, 1, 1'b1, 1);
        expect_slice("spurious", VEC_F, 1);
`ifdef SLICE_PARITY_EN
        check("parity_F", 32'(slice_parity), 32'd1);
`endif
        handshake("spurious", VEC_F, 0);
        check("f3_done", 32'(done), 32'd1);
        tick();
        check("f3_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slice_assembler.md
Name: slice_assembler

Overview:
- Upstream feeder for the 25-bit slice encoder.
- Accepts a serial bitstream, one bit per accepted beat, and assembles 25-bit slices MSB-first.
- Presents each slice to the encoder stage with a valid/ready handshake.
- Counts slices per frame and signals frame completion so the controller can sequence the next phase.

Parameters:
- SLICE_W, 25, bits per slice. Must match the encoder input width.
- NUM_SLICES, 64, slices per frame.
- IDX_W, 6, width of the slice index. Must satisfy 2^IDX_W >= NUM_SLICES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame. Honoured only in IDLE.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  assembler accepts a bit this cycle.
- slice_out  out  SLICE_W  assembled slice; bit 24 is the first bit received.
- slice_valid  out  1  slice_out holds a complete slice.
- slice_ready  in  1  downstream accepts the slice.
- slice_idx  out  IDX_W  index of the slice currently being assembled or presented.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last slice handshake.

Behaviour:
- Clock and reset
  - Single clock: clk.
  - Reset is synchronous and active-high (rst). It overrides every other input, including mid-frame.
  - After the reset edge, all outputs are 0 and the FSM is in IDLE.
  - Any partial slice is discarded.
- State: FSM {IDLE, SHIFT, HOLD, DONE}; bit counter bcnt (0..24); slice counter slice_idx; shift register sreg.
- IDLE
  - bit_ready = 0, slice_valid = 0.
  - On start: bcnt <= 0, slice_idx <= 0, sreg <= 0, go to SHIFT.
- SHIFT
  - bit_ready = 1.
  - Bit transfer occurs when bit_valid && bit_ready: sreg <= {sreg[23:0], bit_in}, bcnt <= bcnt+1.
  - No transfer means sreg and bcnt hold; gaps in bit_valid are legal.
  - A transfer at bcnt == 24 moves to HOLD.
  - Latency: slice_valid rises exactly 1 cycle after the 25th accepted bit.
- HOLD
  - bit_ready = 0.
  - slice_valid = 1; slice_out = sreg, held stable until the handshake.
  - On slice_ready, with slice_idx == NUM_SLICES-1: go to DONE.
  - On slice_ready otherwise: slice_idx++, bcnt <= 0, go to SHIFT.
  - slice_valid drops the cycle after the handshake.
- DONE
  - done = 1 for exactly one cycle, then IDLE.
  - slice_idx holds NUM_SLICES-1 until the next start.
- start is ignored outside IDLE (no restart mid-frame).
- slice_out is registered and keeps its last value when slice_valid = 0. Downstream must qualify it with slice_valid.
- slice_ready is ignored outside HOLD.
- bit_valid while bit_ready = 0 is a non-event; the bit is dropped and the sender must hold it.

Optional Feature:
- Macro: SLICE_PARITY_EN.
- Defined:
  - Adds output port slice_parity (1 bit), a registered XOR-reduction of slice_out.
  - Updates on the same edge as slice_out.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package slice_pkg holds:
  - SLICE_W = 25 and NUM_SLICES = 64.
  - The FSM state enum (IDLE, SHIFT, HOLD, DONE), encoded in 2 bits.
- The encoder and the controller import the same package.
- One natural sub-module: sipo_shift25, the serial-in/parallel-out register with bit counter and a "full" flag. The FSM and slice counter stay in slice_assembler.

Test Plan:
- Basic slice:
  - Stimulus: start, then feed 25'b1111001001001110100010111 MSB-first with bit_valid continuous, slice_ready = 1.
  - Required: slice_out equals that value, slice_valid high 1 cycle after the 25th bit, slice_idx = 0.
- Backpressure and gaps:
  - Stimulus: bit_valid low for 3 cycles mid-slice; slice_ready low for 5 cycles in HOLD.
  - Required: assembled value 25'b1001111101000101010111100 is unaffected. slice_out stays stable and bit_ready stays 0 throughout the hold. Handshake completes on the first slice_ready = 1.
- Frame end (NUM_SLICES = 2 override):
  - Stimulus: two full slices, 25'b1010100000000001010101111 then 25'b0110101010000001100000001.
  - Required: slice_idx 0 then 1. done pulses exactly once, 1 cycle after the 2nd handshake. busy falls with the return to IDLE.
- Reset mid-slice:
  - Stimulus: assert rst after 10 accepted bits.
  - Required: all outputs 0 on the next edge, FSM in IDLE. A new start plus 25'b1101101000001110011011001 assembles correctly with no residue.
- Spurious controls:
  - Stimulus: start pulsed during SHIFT; slice_ready pulsed during SHIFT.
  - Required: no state change; slice_idx and bcnt unaffected.
- Parity (SLICE_PARITY_EN):
  - 25'h0000001 gives slice_parity = 1.
  - 25'b1111001001001110100010111 (14 ones) gives slice_parity = 0.
